layer_compositor: RTL
=====================

Name: layer_compositor

Overview:
- Parametrised N-layer sprite/background compositor. It is the successor to the fixed two-sprite combinational priority mux in the gfx top.
- Sits between the sprite/background generators and the VGA/HDMI output stage.
- Adds a 2-stage registered pipeline, a per-frame layer-enable mask latched at vsync, and per-frame sprite collision reporting.

Parameters:
N_LAYERS, 4, number of sprite layers (1..8); layer 0 has highest priority
COLOR_W, 8, bits per colour channel
ID_W, $clog2(N_LAYERS+1), width of winning-layer index (derived, not overridden)

Ports:
i_clk  in  1  pixel clock
i_rst  in  1  asynchronous reset, active-high
i_valid  in  1  pixel is in active display area
i_v_sync  in  1  vertical sync, active-high; frame boundary = rising edge
i_layer_en_next  in  N_LAYERS  layer enable mask to apply from next frame
i_bg_rgb  in  3*COLOR_W  background colour {r,g,b}
i_layer_rgb  in  N_LAYERS*3*COLOR_W  layer k colour at bits [k*3*COLOR_W +: 3*COLOR_W], {r,g,b}
i_layer_hit  in  N_LAYERS  layer k pixel is opaque at current x,y
o_valid  out  1  output pixel valid
o_red / o_green / o_blue  out  COLOR_W each  composited colour
o_layer_id  out  ID_W  winning layer index; N_LAYERS = background
o_frame_start  out  1  one-cycle pulse, registered, on vsync rising edge
o_collision_mask  out  N_LAYERS  layers that overlapped another enabled layer during previous frame

Behaviour:
- Reset (async, immediate):
  - o_valid, o_red/green/blue, o_frame_start, o_collision_mask = 0.
  - o_layer_id = N_LAYERS.
  - Active mask = all ones; vsync_d = 0; collision accumulator = 0; pipeline valid bits = 0.
- Vsync edge: rise = i_v_sync & ~vsync_d. Vsync held high through reset release counts as a rise on the first clock.
- On rise:
  - active mask <= i_layer_en_next.
  - o_collision_mask <= accumulator (including the rise cycle's contribution).
  - accumulator cleared.
  - o_frame_start = 1 for exactly the next cycle.
- Stage 1 (registered):
  - s1_hit = i_layer_hit & active mask (mask value before any same-cycle update).
  - Registers s1_valid, s1_hit, layer colours and bg colour.
  - A pixel arriving on the rise cycle uses the old mask.
- Stage 2 (registered outputs):
  - Lowest-index set bit of s1_hit wins: rgb = that layer, o_layer_id = index.
  - If no bit is set: rgb = bg, o_layer_id = N_LAYERS.
- Latency: exactly 2 cycles from i_valid/input to o_valid/output. Throughput 1 pixel/cycle, no stalls, no backpressure.
- Blanking: when s1_valid = 0, stage 2 drives rgb = 0, o_layer_id = N_LAYERS, o_valid = 0.
- Collision accumulate:
  - Condition: s1_valid = 1 and popcount(s1_hit) >= 2.
  - Action: accumulator |= s1_hit.
  - If this coincides with a clear, the new accumulator = that cycle's s1_hit only.
- Disabled layers never win arbitration and never contribute to collisions.
- N_LAYERS = 1: no collisions possible; o_collision_mask stays 0.

Optional Feature:
- Macro: COMPOSITOR_COLLISION_EN.
- Defined: accumulator and o_collision_mask behave as above.
- Undefined: accumulator and popcount logic are not generated; o_collision_mask tied to 0. Compositing, latency and o_frame_start are unchanged.

Decomposition:
- gfx_pkg holds:
  - COLOR_W default.
  - rgb_t typedef: struct {r,g,b} each COLOR_W.
  - Function layer_id_w(n) returning $clog2(n+1).
  - Function popcount_ge2 for the collision check.
- Sub-module layer_priority_sel: combinational lowest-index-wins select.
  - Inputs: hit vector, packed colours, bg colour.
  - Outputs: rgb, id.
  - Instantiated in stage 2.

Test Plan (N_LAYERS=4, COLOR_W=8):
1. Reset: assert i_rst mid-stream with hits active -> same cycle o_valid=0, rgb=0, o_layer_id=4, o_collision_mask=0; after release, first pixel appears 2 cycles after i_valid.
2. Priority: hit=4'b0110, layer1=0x112233, layer2=0x445566, bg=0x000080, valid=1 -> 2 cycles later rgb=11/22/33, o_layer_id=1; hit=0 -> rgb=00/00/80, id=4.
3. Mask latch: i_layer_en_next=4'b1101 and vsync rise, with hit=4'b0010 on the rise cycle and on the next cycle -> rise-cycle pixel id=1; next pixel bg, id=4; o_frame_start high one cycle.
4. Collision: in frame A, one pixel with hit=4'b1001, all enabled -> at next vsync rise, o_collision_mask=4'b1001 the following cycle; frame B has no overlap -> 4'b0000 after the subsequent rise.
5. Blanking: i_valid=0 with hit=4'b1111 -> o_valid=0, rgb=0, id=4; no collision accumulated (mask 0 at next rise).
6. Macro undefined: repeat scenario 4 -> o_collision_mask stays 0; rgb/id outputs identical to the macro-defined build.

Source files
------------

// File: rtl/gfx_pkg.sv
// rtl/gfx_pkg.sv - shared graphics types, defaults and helper functions
//
// Holds the default colour channel width, the packed {r,g,b} pixel type,
// the winning-layer index width helper and the collision popcount helper.
package gfx_pkg;

    localparam int COLOR_W_DEFAULT = 8;

    typedef struct packed {
        logic [COLOR_W_DEFAULT-1:0] r;
        logic [COLOR_W_DEFAULT-1:0] g;
        logic [COLOR_W_DEFAULT-1:0] b;
    } rgb_t;

    // Index width able to hold 0..n, where n itself encodes "background".
    function automatic int layer_id_w(input int n);
        return $clog2(n + 1);
    endfunction

    // True when at least two bits are set: clearing the lowest set bit
    // leaves something behind only if there was a second one.
    function automatic logic popcount_ge2(input logic [7:0] v);
        return (v & (v - 8'd1)) != 8'd0;
    endfunction

endpackage

// File: rtl/layer_priority_sel.sv
// rtl/layer_priority_sel.sv - combinational lowest-index-wins layer select
//
// Ports:
//   hit       in  N_LAYERS              per-layer opaque flags (already masked)
//   layer_rgb in  N_LAYERS*3*COLOR_W    layer k colour at [k*3*COLOR_W +: 3*COLOR_W]
//   bg_rgb    in  3*COLOR_W             background colour {r,g,b}
//   rgb       out 3*COLOR_W             selected colour
//   id        out ID_W                  selected layer index, N_LAYERS = background
module layer_priority_sel #(
    parameter int N_LAYERS = 4,
    parameter int COLOR_W  = 8,
    parameter int ID_W     = 3
) (
    input  logic [N_LAYERS-1:0]           hit,
    input  logic [N_LAYERS*3*COLOR_W-1:0] layer_rgb,
    input  logic [3*COLOR_W-1:0]          bg_rgb,
    output logic [3*COLOR_W-1:0]          rgb,
    output logic [ID_W-1:0]               id
);

    // Walk from the lowest priority upward so the last assignment made is
    // the lowest set index.
    always_comb begin
        rgb = bg_rgb;
        id  = ID_W'(N_LAYERS);
        for (int k = N_LAYERS - 1; k >= 0; k--) begin
            if (hit[k]) begin
                rgb = layer_rgb[k*3*COLOR_W +: 3*COLOR_W];
                id  = ID_W'(k);
            end
        end
    end

endmodule

// File: rtl/layer_compositor.sv
// rtl/layer_compositor.sv - N-layer sprite/background compositor, 2-stage pipeline
//
// Optional feature macro: COMPOSITOR_COLLISION_EN (collision accumulator and
// o_collision_mask; when undefined o_collision_mask is tied to 0).
//
// Ports:
//   i_clk, i_rst          pixel clock, asynchronous active-high reset
//   i_valid               pixel in active display area
//   i_v_sync              vertical sync, frame boundary on rising edge
//   i_layer_en_next       layer enable mask taking effect from the next frame
//   i_bg_rgb              background colour {r,g,b}
//   i_layer_rgb           packed layer colours, layer k at [k*3*COLOR_W +: 3*COLOR_W]
//   i_layer_hit           per-layer opaque flags for the current pixel
//   o_valid               output pixel valid (2 cycles after i_valid)
//   o_red/o_green/o_blue  composited colour
//   o_layer_id            winning layer, N_LAYERS = background
//   o_frame_start         one-cycle pulse after a vsync rising edge
//   o_collision_mask      layers that overlapped another enabled layer last frame
module layer_compositor
    import gfx_pkg::*;
#(
    parameter int  N_LAYERS = 4,
    parameter int  COLOR_W  = COLOR_W_DEFAULT,
    localparam int ID_W     = layer_id_w(N_LAYERS)
) (
    input  logic                          i_clk,
    input  logic                          i_rst,
    input  logic                          i_valid,
    input  logic                          i_v_sync,
    input  logic [N_LAYERS-1:0]           i_layer_en_next,
    input  logic [3*COLOR_W-1:0]          i_bg_rgb,
    input  logic [N_LAYERS*3*COLOR_W-1:0] i_layer_rgb,
    input  logic [N_LAYERS-1:0]           i_layer_hit,
    output logic                          o_valid,
    output logic [COLOR_W-1:0]            o_red,
    output logic [COLOR_W-1:0]            o_green,
    output logic [COLOR_W-1:0]            o_blue,
    output logic [ID_W-1:0]               o_layer_id,
    output logic                          o_frame_start,
    output logic [N_LAYERS-1:0]           o_collision_mask
);

    logic                          vsync_d;
    logic                          rise;
    logic [N_LAYERS-1:0]           active_mask;

    logic                          s1_valid;
    logic [N_LAYERS-1:0]           s1_hit;
    logic [N_LAYERS*3*COLOR_W-1:0] s1_layer_rgb;
    logic [3*COLOR_W-1:0]          s1_bg_rgb;

    logic [3*COLOR_W-1:0]          sel_rgb;
    logic [ID_W-1:0]               sel_id;
    logic [3*COLOR_W-1:0]          s2_rgb;

    assign rise = i_v_sync & ~vsync_d;

    // Frame control and stage 1. The hit vector is masked with the mask in
    // force before this edge, so a pixel on the rise cycle still sees the
    // previous frame's enables.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            vsync_d       <= 1'b0;
            active_mask   <= '1;
            o_frame_start <= 1'b0;
            s1_valid      <= 1'b0;
            s1_hit        <= '0;
            s1_layer_rgb  <= '0;
            s1_bg_rgb     <= '0;
        end else begin
            vsync_d       <= i_v_sync;
            o_frame_start <= rise;
            if (rise) begin
                active_mask <= i_layer_en_next;
            end
            s1_valid     <= i_valid;
            s1_hit       <= i_layer_hit & active_mask;
            s1_layer_rgb <= i_layer_rgb;
            s1_bg_rgb    <= i_bg_rgb;
        end
    end

    layer_priority_sel #(
        .N_LAYERS (N_LAYERS),
        .COLOR_W  (COLOR_W),
        .ID_W     (ID_W)
    ) u_sel (
        .hit       (s1_hit),
        .layer_rgb (s1_layer_rgb),
        .bg_rgb    (s1_bg_rgb),
        .rgb       (sel_rgb),
        .id        (sel_id)
    );

    // Stage 2: blanked pixels are forced to black / background id.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            o_valid    <= 1'b0;
            s2_rgb     <= '0;
            o_layer_id <= ID_W'(N_LAYERS);
        end else begin
            o_valid    <= s1_valid;
            s2_rgb     <= s1_valid ? sel_rgb : '0;
            o_layer_id <= s1_valid ? sel_id : ID_W'(N_LAYERS);
        end
    end

    assign o_red   = s2_rgb[3*COLOR_W-1:2*COLOR_W];
    assign o_green = s2_rgb[2*COLOR_W-1:COLOR_W];
    assign o_blue  = s2_rgb[COLOR_W-1:0];

`ifdef COMPOSITOR_COLLISION_EN
    logic [N_LAYERS-1:0] coll_acc;
    logic [7:0]          hit8;
    logic [N_LAYERS-1:0] coll_now;

    always_comb begin
        hit8                 = '0;
        hit8[N_LAYERS-1:0]   = s1_hit;
    end

    assign coll_now = (s1_valid && popcount_ge2(hit8)) ? s1_hit : '0;

    // The pixel sitting in stage 1 on the rise cycle is reported with the
    // closing frame and also seeds the new frame's accumulator.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            coll_acc         <= '0;
            o_collision_mask <= '0;
        end else if (rise) begin
            o_collision_mask <= coll_acc | coll_now;
            coll_acc         <= coll_now;
        end else begin
            coll_acc         <= coll_acc | coll_now;
        end
    end
`else
    assign o_collision_mask = '0;
`endif

endmodule
